// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: holds the pipeline for a
// fixed latency per access, then commits the store or registers the load data.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_to_reg,
  input  logic        reg_to_mem,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  output logic        stall,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        wr_done,
  output logic        req_err
);

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                store_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wr_data_q;
  logic [15:0]         mem [2**ADDR_W];

  logic                req;
  logic                enter_done;
  logic                c_store;
  logic                c_err;
  logic [ADDR_W-1:0]   c_addr;
  logic [15:0]         c_data;

  always_comb begin
    req        = mem_to_reg | reg_to_mem;
    enter_done = 1'b0;
    c_store    = store_q;
    c_err      = err_q;
    c_addr     = addr_q;
    c_data     = wr_data_q;
    if (state_q == StIdle && req && CntInit == 4'd0) begin
      // Single-cycle latency commits on the capture edge, so bypass the registers.
      enter_done = 1'b1;
      c_store    = reg_to_mem;
      c_err      = mem_to_reg & reg_to_mem;
      c_addr     = addr[ADDR_W-1:0];
      c_data     = wr_data;
    end else if (state_q == StWait && cnt_q == 4'd1) begin
      enter_done = 1'b1;
    end
  end

  assign stall = (state_q == StIdle && req && !rst) || (state_q == StWait);

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (!rst && enter_done && c_store) begin
      mem[c_addr] <= c_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      store_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= 16'h0000;
      rd_data   <= 16'h0000;
      rd_valid  <= 1'b0;
      wr_done   <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      req_err  <= 1'b0;
      if (enter_done) begin
        rd_valid <= !c_store;
        wr_done  <= c_store;
        req_err  <= c_err;
        if (!c_store) begin
          rd_data <= mem[c_addr];
        end
      end
      unique case (state_q)
        StIdle: begin
          if (req) begin
            store_q   <= reg_to_mem;
            err_q     <= mem_to_reg & reg_to_mem;
            addr_q    <= addr[ADDR_W-1:0];
            wr_data_q <= wr_data;
            cnt_q     <= CntInit;
            state_q   <= (CntInit == 4'd0) ? StDone : StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=3 instance for the main sequence
// and a LATENCY=1 instance for the back-to-back case; load data via a scoreboard queue.
module tb_dmem_responder;

  localparam int unsigned Lat = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_to_reg, reg_to_mem;
  logic [15:0] addr, wr_data;
  logic        stall, rd_valid, wr_done, req_err;
  logic [15:0] rd_data;

  logic        mem_to_reg1, reg_to_mem1;
  logic [15:0] addr1, wr_data1;
  logic        stall1, rd_valid1, wr_done1, req_err1;
  logic [15:0] rd_data1;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] model [1024];
  logic [15:0] exp_q [$];
  int          pulses;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(Lat)) u_dut (
    .clk(clk), .rst(rst), .mem_to_reg(mem_to_reg), .reg_to_mem(reg_to_mem),
    .addr(addr), .wr_data(wr_data), .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_done(wr_done), .req_err(req_err)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_to_reg(mem_to_reg1), .reg_to_mem(reg_to_mem1),
    .addr(addr1), .wr_data(wr_data1), .stall(stall1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .wr_done(wr_done1), .req_err(req_err1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] obs);
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 16'd1, 16'd0);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  // Called right after a rising edge in an IDLE cycle; returns in the following IDLE cycle.
  task automatic access(input logic ld, input logic st, input logic [15:0] a,
                        input logic [15:0] d);
    mem_to_reg = ld;
    reg_to_mem = st;
    addr       = a;
    wr_data    = d;
    if (st) model[a[9:0]] = d;
    else exp_q.push_back(model[a[9:0]]);
    for (int i = 0; i < Lat; i++) begin
      @(negedge clk);
      chk("stall_busy", 16'(stall), 16'd1);
      if (i == 0) chk("pulses_idle", 16'({rd_valid, wr_done, req_err}), 16'd0);
      @(posedge clk); #1;
    end
    mem_to_reg = 1'b0;
    reg_to_mem = 1'b0;
    @(negedge clk);
    chk("stall_done", 16'(stall), 16'd0);
    chk("rd_valid", 16'(rd_valid), 16'(!st));
    chk("wr_done", 16'(wr_done), 16'(st));
    chk("req_err", 16'(req_err), 16'(ld & st));
    if (rd_valid) pop_chk("rd_data", rd_data);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_to_reg = 1'b1; reg_to_mem = 1'b0; addr = 16'h0012; wr_data = 16'h0;
    mem_to_reg1 = 1'b1; reg_to_mem1 = 1'b0; addr1 = 16'h0; wr_data1 = 16'h0;

    // Reset held with a pending load request.
    repeat (2) begin
      @(negedge clk);
      chk("rst_stall", 16'(stall), 16'd0);
      chk("rst_rd_data", rd_data, 16'h0000);
      chk("rst_pulses", 16'({rd_valid, wr_done, req_err}), 16'd0);
      chk("rst_stall1", 16'(stall1), 16'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_to_reg = 1'b0;
    mem_to_reg1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stall", 16'(stall), 16'd0);
      chk("idle_pulses", 16'({rd_valid, wr_done, req_err}), 16'd0);
    end
    @(posedge clk); #1;

    // Store then load back-to-back.
    access(1'b0, 1'b1, 16'h0012, 16'hBEEF);
    access(1'b1, 1'b0, 16'h0012, 16'h0000);

    // Aliasing of the upper address bits.
    access(1'b0, 1'b1, 16'h0405, 16'h1234);
    access(1'b1, 1'b0, 16'hFC05, 16'h0000);

    // Both request bits: treated as a store with an error pulse.
    access(1'b1, 1'b1, 16'h0020, 16'h00AA);
    access(1'b1, 1'b0, 16'h0020, 16'h0000);

    // Reset in the second stall cycle drops the store.
    access(1'b0, 1'b1, 16'h0030, 16'h1111);
    reg_to_mem = 1'b1; addr = 16'h0030; wr_data = 16'h5555;
    @(negedge clk);
    chk("mid_stall", 16'(stall), 16'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reg_to_mem = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_done", 16'({wr_done, rd_valid, stall}), 16'd0);
    end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 16'h0030, 16'h0000);

    // LATENCY=1 instance: one store, then a continuously held load.
    reg_to_mem1 = 1'b1; addr1 = 16'h0044; wr_data1 = 16'hCAFE;
    @(negedge clk);
    chk("l1_st_stall", 16'(stall1), 16'd1);
    @(posedge clk); #1;
    reg_to_mem1 = 1'b0;
    @(negedge clk);
    chk("l1_wr_done", 16'(wr_done1), 16'd1);
    chk("l1_st_stall_done", 16'(stall1), 16'd0);
    @(posedge clk); #1;
    mem_to_reg1 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("l1_stall", 16'(stall1), 16'((i % 2) == 0));
      chk("l1_rd_valid", 16'(rd_valid1), 16'((i % 2) == 1));
      if (rd_valid1) begin
        pulses++;
        chk("l1_rd_data", rd_data1, 16'hCAFE);
      end
      @(posedge clk); #1;
    end
    mem_to_reg1 = 1'b0;
    chk("l1_pulse_count", 16'(pulses), 16'd4);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
